// File: rtl/game_fsm_controller_if.sv
// Control/status bundle between the pong match sequencer and the surrounding game logic.
// master drives buttons, tick and score inputs; slave is the sequencer.
interface game_fsm_controller_if;
  logic       timing_tick;
  logic       start;
  logic       pause;
  logic       point_p1;
  logic       point_p2;
  logic [3:0] player1_score;
  logic [3:0] player2_score;
  logic [2:0] game_state;
  logic       ball_hold;
  logic       ball_run;
  logic       serve_dir;
  logic       score_clear;
  logic [1:0] winner;

  modport master (
    output timing_tick, start, pause, point_p1, point_p2, player1_score, player2_score,
    input  game_state, ball_hold, ball_run, serve_dir, score_clear, winner
  );

  modport slave (
    input  timing_tick, start, pause, point_p1, point_p2, player1_score, player2_score,
    output game_state, ball_hold, ball_run, serve_dir, score_clear, winner
  );
endinterface

// File: rtl/game_fsm_controller.sv
// Pong match sequencer: idle, serve, play, point pause and game over, with registered strobes.
// Define GAME_PAUSE_EN to enable the PAUSED state driven by the pause button.
module game_fsm_controller #(
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned SERVE_TICKS = 60,
  parameter int unsigned POINT_TICKS = 90
) (
  input logic                  clk,
  input logic                  rst,
  game_fsm_controller_if.slave bus
);

  localparam int unsigned CntW = 16;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StServe    = 3'd1;
  localparam logic [2:0] StPlay     = 3'd2;
  localparam logic [2:0] StPoint    = 3'd3;
  localparam logic [2:0] StGameOver = 3'd4;
  localparam logic [2:0] StPaused   = 3'd5;

  localparam logic [3:0]      WinScore  = 4'(WIN_SCORE);
  localparam logic [CntW-1:0] ServeLoad = CntW'(SERVE_TICKS);
  localparam logic [CntW-1:0] PointLoad = CntW'(POINT_TICKS);

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic [1:0]      win_q, win_d;
  logic            clr_q, clr_d;
  logic            hold_q, hold_d;
  logic            run_q, run_d;
  logic            start_q, pause_q, valid_q;
  logic            start_edge, pause_edge, tick_done;

  // valid_q masks the first sample after reset so a held button gives no edge.
  assign start_edge = valid_q & bus.start & ~start_q;
  assign pause_edge = valid_q & bus.pause & ~pause_q;
  assign tick_done  = bus.timing_tick & (cnt_q <= CntW'(1));

`ifndef GAME_PAUSE_EN
  logic unused_pause;
  assign unused_pause = pause_edge;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    win_d   = win_q;
    clr_d   = 1'b0;
    case (state_q)
      StIdle, StGameOver: begin
        if (start_edge) begin
          state_d = StServe;
          cnt_d   = ServeLoad;
          clr_d   = 1'b1;
          dir_d   = 1'b0;
          win_d   = 2'b00;
        end
      end
      StServe: begin
        if (tick_done) begin
          state_d = StPlay;
        end else if (bus.timing_tick) begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StPlay: begin
        if (bus.point_p1) begin
          state_d = StPoint;
          cnt_d   = PointLoad;
          dir_d   = 1'b1;
        end else if (bus.point_p2) begin
          state_d = StPoint;
          cnt_d   = PointLoad;
          dir_d   = 1'b0;
`ifdef GAME_PAUSE_EN
        end else if (pause_edge) begin
          state_d = StPaused;
`endif
        end
      end
      StPoint: begin
        if (tick_done) begin
          if (bus.player1_score >= WinScore) begin
            state_d = StGameOver;
            win_d   = 2'b01;
          end else if (bus.player2_score >= WinScore) begin
            state_d = StGameOver;
            win_d   = 2'b10;
          end else begin
            state_d = StServe;
            cnt_d   = ServeLoad;
          end
        end else if (bus.timing_tick) begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
`ifdef GAME_PAUSE_EN
      StPaused: begin
        if (pause_edge) begin
          state_d = StPlay;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they track it without a cycle of lag.
  always_comb begin
    hold_d = (state_d == StIdle) || (state_d == StServe) || (state_d == StPoint) ||
             (state_d == StGameOver);
    run_d  = (state_d == StPlay);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      win_q   <= 2'b00;
      clr_q   <= 1'b0;
      hold_q  <= 1'b1;
      run_q   <= 1'b0;
      start_q <= 1'b0;
      pause_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      win_q   <= win_d;
      clr_q   <= clr_d;
      hold_q  <= hold_d;
      run_q   <= run_d;
      start_q <= bus.start;
      pause_q <= bus.pause;
      valid_q <= 1'b1;
    end
  end

  assign bus.game_state  = state_q;
  assign bus.ball_hold   = hold_q;
  assign bus.ball_run    = run_q;
  assign bus.serve_dir   = dir_q;
  assign bus.score_clear = clr_q;
  assign bus.winner      = win_q;

endmodule

// File: tb/tb_game_fsm_controller.sv
// Directed vector bench for game_fsm_controller; pause vectors follow GAME_PAUSE_EN.
module tb_game_fsm_controller;

  typedef struct {
    string      name;
    bit         rst;
    bit         start, pause, p1, p2, tick;
    logic [3:0] s1, s2;
    int         rep;
    logic [2:0] st;
    bit         hold, run, dir, clr;
    logic [1:0] win;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  game_fsm_controller_if bus ();

  game_fsm_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string name, bit start, bit pause, bit p1, bit p2, bit tick,
                              logic [3:0] s1, logic [3:0] s2, int rep, logic [2:0] st,
                              bit hold, bit run, bit dir, bit clr, logic [1:0] win);
    vec_t v;
    v.name = name; v.rst = 1'b0;
    v.start = start; v.pause = pause; v.p1 = p1; v.p2 = p2; v.tick = tick;
    v.s1 = s1; v.s2 = s2; v.rep = rep;
    v.st = st; v.hold = hold; v.run = run; v.dir = dir; v.clr = clr; v.win = win;
    return v;
  endfunction

  task automatic check(input vec_t v);
    logic [8:0] got, exp;
    got = {bus.game_state, bus.ball_hold, bus.ball_run, bus.serve_dir, bus.score_clear,
           bus.winner};
    exp = {v.st, v.hold, v.run, v.dir, v.clr, v.win};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got state=%0d hold=%b run=%b dir=%b clr=%b win=%b, want state=%0d hold=%b run=%b dir=%b clr=%b win=%b",
               v.name, got[8:6], got[5], got[4], got[3], got[2], got[1:0],
               v.st, v.hold, v.run, v.dir, v.clr, v.win);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.start = v.start; bus.pause = v.pause; bus.point_p1 = v.p1; bus.point_p2 = v.p2;
    bus.timing_tick = v.tick; bus.player1_score = v.s1; bus.player2_score = v.s2;
  endtask

  initial begin
    vec_t rv;
    // Held start through reset must not register as an edge.
    vecs.push_back(mk("held_start",   1,0,0,0,0, 0,0,  3, 0, 1,0,0,0,2'b00));
    vecs.push_back(mk("idle_rel",     0,0,0,0,0, 0,0,  1, 0, 1,0,0,0,2'b00));
    vecs.push_back(mk("start_edge",   1,0,0,0,0, 0,0,  1, 1, 1,0,0,1,2'b00));
    vecs.push_back(mk("clr_one_cyc",  0,0,0,0,0, 0,0,  1, 1, 1,0,0,0,2'b00));
    vecs.push_back(mk("serve_59",     0,0,0,0,1, 0,0, 59, 1, 1,0,0,0,2'b00));
    vecs.push_back(mk("serve_60",     0,0,0,0,1, 0,0,  1, 2, 0,1,0,0,2'b00));
    vecs.push_back(mk("p1_point",     0,0,1,0,0, 3,2,  1, 3, 1,0,1,0,2'b00));
    vecs.push_back(mk("point_89",     0,0,0,0,1, 3,2, 89, 3, 1,0,1,0,2'b00));
    vecs.push_back(mk("point_90",     0,0,0,0,1, 3,2,  1, 1, 1,0,1,0,2'b00));
    vecs.push_back(mk("p2_in_serve",  0,0,0,1,0, 3,2,  1, 1, 1,0,1,0,2'b00));
    vecs.push_back(mk("serve_to_play",0,0,0,0,1, 3,2, 60, 2, 0,1,1,0,2'b00));
    vecs.push_back(mk("start_in_play",1,0,0,0,0, 3,2,  1, 2, 0,1,1,0,2'b00));
    vecs.push_back(mk("start_low",    0,0,0,0,0, 3,2,  1, 2, 0,1,1,0,2'b00));
`ifdef GAME_PAUSE_EN
    vecs.push_back(mk("pause_enter",  0,1,0,0,0, 3,2,  1, 5, 0,0,1,0,2'b00));
    vecs.push_back(mk("pause_p1_ign", 0,1,0,1,0, 3,2,  1, 5, 0,0,1,0,2'b00));
    vecs.push_back(mk("pause_p1_ign2",0,1,1,0,0, 3,2,  1, 5, 0,0,1,0,2'b00));
    vecs.push_back(mk("pause_tick",   0,1,0,0,1, 3,2,  5, 5, 0,0,1,0,2'b00));
    vecs.push_back(mk("pause_low",    0,0,0,0,0, 3,2,  1, 5, 0,0,1,0,2'b00));
    vecs.push_back(mk("pause_exit",   0,1,0,0,0, 3,2,  1, 2, 0,1,1,0,2'b00));
    vecs.push_back(mk("pause_rel",    0,0,0,0,0, 3,2,  1, 2, 0,1,1,0,2'b00));
`else
    vecs.push_back(mk("pause_ignored",0,1,0,0,0, 3,2,  1, 2, 0,1,1,0,2'b00));
    vecs.push_back(mk("pause_rel",    0,0,0,0,0, 3,2,  1, 2, 0,1,1,0,2'b00));
`endif
    vecs.push_back(mk("p2_point",     0,0,0,1,0, 3,9,  1, 3, 1,0,0,0,2'b00));
    vecs.push_back(mk("p2_wait_89",   0,0,0,0,1, 3,9, 89, 3, 1,0,0,0,2'b00));
    vecs.push_back(mk("p2_wins",      0,0,0,0,1, 3,9,  1, 4, 1,0,0,0,2'b10));
    vecs.push_back(mk("p1_in_gover",  0,0,1,0,0, 3,9,  1, 4, 1,0,0,0,2'b10));
    vecs.push_back(mk("restart",      1,0,0,0,0, 3,9,  1, 1, 1,0,0,1,2'b00));
    vecs.push_back(mk("restart_rel",  0,0,0,0,0, 0,0,  1, 1, 1,0,0,0,2'b00));
    vecs.push_back(mk("serve_again",  0,0,0,0,1, 0,0, 60, 2, 0,1,0,0,2'b00));
    vecs.push_back(mk("both_points",  0,0,1,1,0, 0,0,  1, 3, 1,0,1,0,2'b00));
    vecs.push_back(mk("point_50",     0,0,0,0,1, 0,0, 50, 3, 1,0,1,0,2'b00));
    rv = mk("rst_mid_point",          0,0,0,0,0, 0,0,  1, 0, 1,0,0,0,2'b00);
    rv.rst = 1'b1;
    vecs.push_back(rv);
    vecs.push_back(mk("idle_89_ticks",0,0,0,0,1, 0,0, 89, 0, 1,0,0,0,2'b00));
    vecs.push_back(mk("start3",       1,0,0,0,0, 0,0,  1, 1, 1,0,0,1,2'b00));
    vecs.push_back(mk("start3_rel",   0,0,0,0,0, 0,0,  1, 1, 1,0,0,0,2'b00));
    vecs.push_back(mk("serve3",       0,0,0,0,1, 0,0, 60, 2, 0,1,0,0,2'b00));
    vecs.push_back(mk("p1_point3",    0,0,1,0,0,15,9,  1, 3, 1,0,1,0,2'b00));
    vecs.push_back(mk("p1_wins_prio", 0,0,0,0,1,15,9, 90, 4, 1,0,1,0,2'b01));
    vecs.push_back(mk("start4",       1,0,0,0,0, 0,0,  1, 1, 1,0,0,1,2'b00));
    vecs.push_back(mk("start4_rel",   0,0,0,0,0, 0,0,  1, 1, 1,0,0,0,2'b00));
    vecs.push_back(mk("serve4",       0,0,0,0,1, 0,0, 60, 2, 0,1,0,0,2'b00));
    vecs.push_back(mk("p2_point4",    0,0,0,1,0, 8,8,  1, 3, 1,0,0,0,2'b00));
    vecs.push_back(mk("below_win",    0,0,0,0,1, 8,8, 90, 1, 1,0,0,0,2'b00));

    // Reset with start held high.
    drive(vecs[0]);
    repeat (2) @(negedge clk);
    rv = mk("reset_vals", 0,0,0,0,0, 0,0, 0, 0, 1,0,0,0,2'b00);
    check(rv);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) begin
        drive(vecs[i]);
        rst = 1'b1;
        #1;
        check(vecs[i]);
        @(negedge clk);
        rst = 1'b0;
      end else begin
        drive(vecs[i]);
        repeat (vecs[i].rep) @(posedge clk);
        @(negedge clk);
        check(vecs[i]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
